// File: rtl/Asynchronous_FIFO_pkg.sv
// Shared constants and types for the FIFO family: default geometry and a flag bundle.
package Asynchronous_FIFO_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_flags_t;

endpackage

// File: rtl/fifo_mem.sv
// 1-write/1-read register array: synchronous write, asynchronous read, contents never reset.
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  // Storage write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy count, threshold flags, sticky errors and synchronous flush.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default build uses registered reads.
module sync_fifo_param
  import Asynchronous_FIFO_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 4,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  flush,
  input  logic                  clr_err,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0]   AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO = (ADDR_WIDTH+1)'(0);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [ADDR_WIDTH:0]   count_r;
  logic [ADDR_WIDTH:0]   count_nxt_s;
  logic                  full_r;
  logic                  empty_r;
  logic                  almost_full_r;
  logic                  almost_empty_r;
  logic                  overflow_r;
  logic                  underflow_r;
  logic                  wr_acc_s;
  logic                  rd_acc_s;
  logic [DATA_WIDTH-1:0] rd_data_s;

  // Flush cancels both transfers so the flushed-cycle write never lands.
  assign wr_acc_s = wr_en & ~full_r  & ~flush;
  assign rd_acc_s = rd_en & ~empty_r & ~flush;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc_s),
    .wr_addr (wr_ptr_r),
    .wr_data (data_in),
    .rd_addr (rd_ptr_r),
    .rd_data (rd_data_s)
  );

  // Next occupancy from accepted transfers.
  always_comb begin
    count_nxt_s = count_r;
    if (flush) begin
      count_nxt_s = CNT_ZERO;
    end else begin
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_nxt_s = count_r + CNT_ONE;
        2'b01:   count_nxt_s = count_r - CNT_ONE;
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Pointers, count and status flags; flags are registered from the next count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r       <= '0;
      rd_ptr_r       <= '0;
      count_r        <= '0;
      full_r         <= 1'b0;
      empty_r        <= 1'b1;
      almost_full_r  <= (CNT_ZERO >= AF_C);
      almost_empty_r <= (CNT_ZERO <= AE_C);
    end else begin
      if (flush) begin
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
      end else begin
        if (wr_acc_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_ONE;
        end
        if (rd_acc_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
      end
      count_r        <= count_nxt_s;
      full_r         <= (count_nxt_s == DEPTH_C);
      empty_r        <= (count_nxt_s == CNT_ZERO);
      almost_full_r  <= (count_nxt_s >= AF_C);
      almost_empty_r <= (count_nxt_s <= AE_C);
    end
  end

  // Sticky error flags; a new error outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_en && full_r) begin
        overflow_r <= 1'b1;
      end else if (clr_err) begin
        overflow_r <= 1'b0;
      end
      if (rd_en && empty_r) begin
        underflow_r <= 1'b1;
      end else if (clr_err) begin
        underflow_r <= 1'b0;
      end
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign data_out   = rd_data_s;
  assign data_valid = ~empty_r;
`else
  logic [DATA_WIDTH-1:0] data_out_r;
  logic                  data_valid_r;

  // Registered read port: data_out holds between pops, data_valid pulses per pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_r   <= '0;
      data_valid_r <= 1'b0;
    end else if (flush) begin
      data_valid_r <= 1'b0;
    end else if (rd_acc_s) begin
      data_out_r   <= rd_data_s;
      data_valid_r <= 1'b1;
    end else begin
      data_valid_r <= 1'b0;
    end
  end

  assign data_out   = data_out_r;
  assign data_valid = data_valid_r;
`endif

  assign full         = full_r;
  assign empty        = empty_r;
  assign almost_full  = almost_full_r;
  assign almost_empty = almost_empty_r;
  assign count        = count_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised and directed bench for sync_fifo_param against a queue-based reference model.
module tb_sync_fifo_param;
  import Asynchronous_FIFO_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          rd_en = 1'b0;
  logic          flush = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
  logic [AW:0]   count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;
  logic [DW-1:0] m_dout = '0;
  logic          m_dv = 1'b0;

  sync_fifo_param #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .AF_THRESH  (AF),
    .AE_THRESH  (AE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .rd_en        (rd_en),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .flush        (flush),
    .clr_err      (clr_err),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    m_dout = '0;
    m_dv   = 1'b0;
  endtask

  task automatic model_update(input logic w, input logic [DW-1:0] d, input logic r,
                              input logic f, input logic c);
    bit was_full  = (q.size() == DEPTH);
    bit was_empty = (q.size() == 0);
    if (w && was_full) m_ovf = 1'b1;
    else if (c)        m_ovf = 1'b0;
    if (r && was_empty) m_udf = 1'b1;
    else if (c)         m_udf = 1'b0;
    if (f) begin
      q.delete();
      m_dv = 1'b0;
    end else begin
      if (r && !was_empty) begin
        m_dout = q.pop_front();
        m_dv   = 1'b1;
      end else begin
        m_dv = 1'b0;
      end
      if (w && !was_full) q.push_back(d);
    end
  endtask

  task automatic check_outputs(input string tag);
    fifo_flags_t obs_f, exp_f;
    int n = q.size();
    obs_f = '{full, empty, almost_full, almost_empty, overflow, underflow};
    exp_f = '{(n == DEPTH), (n == 0), (n >= AF), (n <= AE), m_ovf, m_udf};
    check({tag, ".count"}, 32'(count), 32'(n));
    check({tag, ".flags"}, 32'(obs_f), 32'(exp_f));
`ifdef SYNC_FIFO_FWFT_EN
    check({tag, ".data_valid"}, 32'(data_valid), 32'(n != 0));
    if (n != 0) check({tag, ".data_out"}, 32'(data_out), 32'(q[0]));
`else
    check({tag, ".data_valid"}, 32'(data_valid), 32'(m_dv));
    check({tag, ".data_out"}, 32'(data_out), 32'(m_dout));
`endif
  endtask

  task automatic step(input string tag, input logic w, input logic [DW-1:0] d,
                      input logic r, input logic f, input logic c);
    @(negedge clk);
    wr_en = w; data_in = d; rd_en = r; flush = f; clr_err = c;
    model_update(w, d, r, f, c);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    // Reset and check the reset state before any clock edge
    #1 rst_n = 1'b0;
    model_reset();
    #2;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: fill with 0x00..0x0F, then drain in order
    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // 2: overflow while full with a simultaneous read
    for (int i = 0; i < DEPTH; i++) step("fill2", 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    step("ovf", 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    step("clr_ovf", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH - 1; i++) step("drain2", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // 3: underflow while empty with a simultaneous write
    step("udf", 1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    step("udf_rd", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step("clr_udf", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // 4: streaming read+write across two pointer wraps
    for (int i = 0; i < 3; i++) step("prime", 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step("stream", 1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);

    // 5: flush with a concurrent write, then a clean round trip
    for (int i = 0; i < 4; i++) step("load", 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    step("flush", 1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    step("post_wr", 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    step("post_rd", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Randomised traffic with occasional flush and error clear
    for (int i = 0; i < 500; i++) begin
      step("rand", 1'($urandom_range(0, 99) < 55), 8'($urandom),
           1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 63) == 0),
           1'($urandom_range(0, 15) == 0));
    end

    // 6: asynchronous reset mid-burst at count 9
    step("pre_rst_flush", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) step("burst", 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    check("burst.level", 32'(count), 32'd9);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
    step("after_rst_wr", 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
    step("after_rst_rd", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
